// File: rtl/nru_history_updater_pkg.sv
// Shared NRU history definitions: FSM encoding, all-ones mask and set-address width helpers.
// Used by the history updater and by victim-side lookahead logic.
package nru_history_updater_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned NRU_MAX_WAY = 64;

    function automatic logic [NRU_MAX_WAY-1:0] nru_all_ones(input int unsigned num_way);
        logic [NRU_MAX_WAY-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NRU_MAX_WAY; i++) begin
            if (i < num_way) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic int unsigned nru_set_addr_width(input int unsigned num_set);
        return (num_set < 2) ? 1 : $clog2(num_set);
    endfunction

endpackage

// File: rtl/nru_dp_array.sv
// History storage: one synchronous write port, two asynchronous read ports.
// Combinational read, write lands on the clock edge; no backpressure.
module nru_dp_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk_in,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdat,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdat_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdat_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (i_we) r_mem[i_waddr] <= i_wdat;
    end

    assign o_rdat_a = r_mem[i_raddr_a];
    assign o_rdat_b = r_mem[i_raddr_b];

endmodule

// File: rtl/nru_history_next.sv
// Next NRU history vector: OR in the used way(s), collapse to just those ways on saturation.
// Purely combinational; a zero way vector passes the old vector through unchanged.
module nru_history_next
    import nru_history_updater_pkg::*;
#(
    parameter int NUM_WAY = 8
) (
    input  logic [NUM_WAY-1:0] i_old,
    input  logic [NUM_WAY-1:0] i_way,
    output logic [NUM_WAY-1:0] o_new
);

    localparam logic [NUM_WAY-1:0] ALL_ONES = NUM_WAY'(nru_all_ones(NUM_WAY));

    logic [NUM_WAY-1:0] w_or;
    assign w_or = i_old | i_way;

    always_comb begin
        o_new = w_or;
        if (i_way == '0)          o_new = i_old;
        else if (w_or == ALL_ONES) o_new = i_way;
    end

endmodule

// File: rtl/nru_history_updater.sv
// NRU history owner: clears the array after reset, then runs a 2-stage RMW per "way used" event.
// Write lands 2 edges after acceptance; victim read port has 1-cycle latency and sees pending writes.
module nru_history_updater
    import nru_history_updater_pkg::*;
#(
    parameter int NUM_WAY        = 8,
    parameter int NUM_SET        = 64,
    parameter int SET_ADDR_WIDTH = nru_set_addr_width(NUM_SET)
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      update_valid_in,
    output logic                      update_ready_out,
    input  logic [SET_ADDR_WIDTH-1:0] update_set_addr_in,
    input  logic [NUM_WAY-1:0]        update_way_decoded_in,
    input  logic                      history_read_en_in,
    input  logic [SET_ADDR_WIDTH-1:0] history_read_set_addr_in,
    output logic [NUM_WAY-1:0]        history_read_data_out,
    output logic                      init_done_out
);

    localparam logic [SET_ADDR_WIDTH-1:0] SWEEP_LAST = SET_ADDR_WIDTH'(NUM_SET - 1);

    logic [0:0]                r_state;
    logic [SET_ADDR_WIDTH-1:0] r_sweep;
    logic                      r_s0_vld;
    logic [SET_ADDR_WIDTH-1:0] r_s0_set;
    logic [NUM_WAY-1:0]        r_s0_way;
    logic                      r_s1_vld;
    logic [SET_ADDR_WIDTH-1:0] r_s1_set;
    logic [NUM_WAY-1:0]        r_s1_way;
    logic [NUM_WAY-1:0]        r_s1_old;
    logic [NUM_WAY-1:0]        r_rd_dat;

    logic                      w_init;
    logic                      w_accept;
    logic                      w_s1_wr;
    logic [NUM_WAY-1:0]        w_s1_new;
    logic [NUM_WAY-1:0]        w_s0_old;
    logic                      w_arr_we;
    logic [SET_ADDR_WIDTH-1:0] w_arr_waddr;
    logic [NUM_WAY-1:0]        w_arr_wdat;
    logic [NUM_WAY-1:0]        w_arr_upd_dat;
    logic [NUM_WAY-1:0]        w_arr_rd_dat;

    assign w_init   = (r_state == ST_INIT);
    assign w_accept = update_valid_in & ~w_init;
    assign w_s1_wr  = r_s1_vld & (|r_s1_way);

    // Writes are suppressed while reset is asserted so in-flight updates are dropped.
    assign w_arr_we    = ~reset_in & (w_init | w_s1_wr);
    assign w_arr_waddr = w_init ? r_sweep : r_s1_set;
    assign w_arr_wdat  = w_init ? '0 : w_s1_new;

    nru_history_next #(.NUM_WAY(NUM_WAY)) u_next (
        .i_old (r_s1_old),
        .i_way (r_s1_way),
        .o_new (w_s1_new)
    );

    nru_dp_array #(.WIDTH(NUM_WAY), .DEPTH(NUM_SET), .AW(SET_ADDR_WIDTH)) u_array (
        .clk_in    (clk_in),
        .i_we      (w_arr_we),
        .i_waddr   (w_arr_waddr),
        .i_wdat    (w_arr_wdat),
        .i_raddr_a (r_s0_set),
        .o_rdat_a  (w_arr_upd_dat),
        .i_raddr_b (history_read_set_addr_in),
        .o_rdat_b  (w_arr_rd_dat)
    );

    // The S1 write lands on the same edge S0 samples the array, so a same-set S1 result is forwarded.
    assign w_s0_old = (r_s1_vld && (r_s1_set == r_s0_set)) ? w_s1_new : w_arr_upd_dat;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state  <= ST_INIT;
            r_sweep  <= '0;
            r_s0_vld <= 1'b0;
            r_s1_vld <= 1'b0;
            r_rd_dat <= '0;
        end else begin
            if (w_init) begin
                r_sweep <= r_sweep + SET_ADDR_WIDTH'(1);
                if (r_sweep == SWEEP_LAST) r_state <= ST_RUN;
            end

            r_s0_vld <= w_accept;
            if (w_accept) begin
                r_s0_set <= update_set_addr_in;
                r_s0_way <= update_way_decoded_in;
            end

            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_s1_set <= r_s0_set;
                r_s1_way <= r_s0_way;
                r_s1_old <= w_s0_old;
            end

            if (history_read_en_in) begin
                if (w_init)
                    r_rd_dat <= '0;
                else if (w_s1_wr && (r_s1_set == history_read_set_addr_in))
                    r_rd_dat <= w_s1_new;
                else
                    r_rd_dat <= w_arr_rd_dat;
            end
        end
    end

    assign update_ready_out      = ~w_init;
    assign init_done_out         = ~w_init;
    assign history_read_data_out = r_rd_dat;

endmodule

// File: tb/tb_nru_history_updater.sv
// Directed bench for nru_history_updater: reference history model plus a read scoreboard queue.
module tb_nru_history_updater;

    localparam int NUM_WAY = 8;
    localparam int NUM_SET = 64;
    localparam int AW      = 6;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          update_valid_in;
    logic          update_ready_out;
    logic [AW-1:0] update_set_addr_in;
    logic [7:0]    update_way_decoded_in;
    logic          history_read_en_in;
    logic [AW-1:0] history_read_set_addr_in;
    logic [7:0]    history_read_data_out;
    logic          init_done_out;

    always #5 clk_in = ~clk_in;

    nru_history_updater #(.NUM_WAY(NUM_WAY), .NUM_SET(NUM_SET), .SET_ADDR_WIDTH(AW)) dut (
        .clk_in                   (clk_in),
        .reset_in                 (reset_in),
        .update_valid_in          (update_valid_in),
        .update_ready_out         (update_ready_out),
        .update_set_addr_in       (update_set_addr_in),
        .update_way_decoded_in    (update_way_decoded_in),
        .history_read_en_in       (history_read_en_in),
        .history_read_set_addr_in (history_read_set_addr_in),
        .history_read_data_out    (history_read_data_out),
        .init_done_out            (init_done_out)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_mem [NUM_SET];
    logic [7:0] sb_q [$];

    function automatic logic [7:0] model_next(input logic [7:0] old, input logic [7:0] way);
        if (way == 8'h00) return old;
        if ((old | way) == 8'hFF) return way;
        return old | way;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic upd(input int set, input logic [7:0] way);
        update_valid_in       = 1'b1;
        update_set_addr_in    = AW'(set);
        update_way_decoded_in = way;
        exp_mem[set]          = model_next(exp_mem[set], way);
        tick();
        update_valid_in       = 1'b0;
        update_way_decoded_in = 8'h00;
    endtask

    task automatic rd(input int set, input string tag);
        logic [7:0] expv;
        history_read_en_in       = 1'b1;
        history_read_set_addr_in = AW'(set);
        sb_q.push_back(exp_mem[set]);
        tick();
        history_read_en_in = 1'b0;
        expv = sb_q.pop_front();
        check(tag, {24'h0, history_read_data_out}, {24'h0, expv});
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (!update_ready_out && cyc < 200) begin
            tick();
            cyc++;
        end
        check(tag, cyc, 64);
        check("init_done_after_sweep", {31'h0, init_done_out}, 32'h1);
    endtask

    initial begin
        reset_in                 = 1'b1;
        update_valid_in          = 1'b0;
        update_set_addr_in       = '0;
        update_way_decoded_in    = 8'h00;
        history_read_en_in       = 1'b0;
        history_read_set_addr_in = '0;
        for (int i = 0; i < NUM_SET; i++) exp_mem[i] = 8'h00;

        repeat (3) tick();
        check("reset_ready", {31'h0, update_ready_out}, 32'h0);
        check("reset_init_done", {31'h0, init_done_out}, 32'h0);
        check("reset_rdata", {24'h0, history_read_data_out}, 32'h0);

        // Sweep with a read held open: reads during the sweep must stay zero.
        reset_in                 = 1'b0;
        history_read_en_in       = 1'b1;
        history_read_set_addr_in = AW'(31);
        wait_init("init_cycles");
        check("init_read_zero", {24'h0, history_read_data_out}, 32'h0);
        history_read_en_in = 1'b0;
        check("run_ready", {31'h0, update_ready_out}, 32'h1);

        rd(0,  "init_set0");
        rd(31, "init_set31");
        rd(63, "init_set63");

        upd(5, 8'h01); repeat (2) tick();
        upd(5, 8'h04); repeat (2) tick();
        upd(5, 8'h10); repeat (2) tick();
        rd(5, "set5_accum");
        check("set5_const", {24'h0, history_read_data_out}, 32'h15);

        for (int b = 0; b < 7; b++) upd(9, 8'(1 << b));
        repeat (2) tick();
        rd(9, "set9_preload");
        upd(9, 8'h80); repeat (2) tick();
        rd(9, "set9_collapse");
        check("set9_const", {24'h0, history_read_data_out}, 32'h80);

        upd(3, 8'h02); upd(3, 8'h08); upd(3, 8'h20);
        repeat (2) tick();
        rd(3, "set3_b2b");
        check("set3_b2b_const", {24'h0, history_read_data_out}, 32'h2A);
        upd(3, 8'h04); upd(3, 8'h10); upd(3, 8'h40); upd(3, 8'h80);
        repeat (2) tick();
        rd(3, "set3_fe");
        upd(3, 8'h01); upd(3, 8'h02);
        repeat (2) tick();
        rd(3, "set3_collapse_b2b");
        check("set3_collapse_const", {24'h0, history_read_data_out}, 32'h03);

        // Read lands on the very edge the write lands.
        upd(12, 8'h40); tick();
        rd(12, "set12_write_first");
        check("set12_const", {24'h0, history_read_data_out}, 32'h40);
        history_read_set_addr_in = AW'(5);
        repeat (3) tick();
        check("read_hold", {24'h0, history_read_data_out}, 32'h40);
        upd(12, 8'h00); repeat (2) tick();
        rd(12, "set12_zero_way");

        upd(7, 8'h0F); upd(7, 8'hF0);
        repeat (2) tick();
        rd(7, "set7_multihot");
        check("set7_const", {24'h0, history_read_data_out}, 32'hF0);

        upd(14, 8'h02); upd(12, 8'h01); tick();
        rd(12, "set12_after_interleave");
        rd(14, "set14_other_set");

        // Reset with updates in both pipeline stages; they must never land.
        upd(20, 8'h01); upd(21, 8'h02);
        reset_in = 1'b1;
        tick(); tick();
        check("midreset_ready", {31'h0, update_ready_out}, 32'h0);
        check("midreset_rdata", {24'h0, history_read_data_out}, 32'h0);
        for (int i = 0; i < NUM_SET; i++) exp_mem[i] = 8'h00;
        reset_in = 1'b0;
        wait_init("reinit_cycles");
        repeat (2) tick();
        for (int s = 0; s < NUM_SET; s++) rd(s, "post_reset_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
